pool_window_gen: RTL and testbench

- Feeds the max-pooling stage directly from upstream: takes a raster-order pixel stream from the conv/activation stage and assembles non-overlapping 2x2 pooling windows (stride 2).
- Buffers one even row internally and emits a 4-element window, plus its output coordinates, in the parallel-vector form the pooling stage consumes.
- Fixed stride/pool of 2x2; frame geometry set by parameters.

---
 rtl/pool_window_gen.sv | 137 +++++++++++++
 tb/tb_pool_window_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_gen.sv
// pool_window_gen: builds non-overlapping 2x2 (stride 2) pooling windows from a
// raster-order pixel stream. Even rows are captured in a one-row line buffer;
// on odd rows the even-column pixel is held, and the odd-column pixel completes
// a window that is presented as a registered 4-element vector plus its
// output-map coordinates.
//
// Window element order: [0]=top-left, [1]=top-right, [2]=bottom-left,
// [3]=bottom-right. POOL_SIZE must stay at 4.
module pool_window_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28,
   parameter int POOL_SIZE  = 4,
   // Output-map coordinate widths; kept at least 1 bit for 2- or 3-pixel dimensions.
   localparam int ROW_W = ((IMG_HEIGHT / 2) > 1) ? $clog2(IMG_HEIGHT / 2) : 1,
   localparam int COL_W = ((IMG_WIDTH / 2) > 1) ? $clog2(IMG_WIDTH / 2) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [DATA_WIDTH-1:0] pix_in,
   input  logic                         pix_valid,
   output logic signed [DATA_WIDTH-1:0] win_out [POOL_SIZE-1:0],
   output logic                         win_valid,
   output logic [ROW_W-1:0]             win_row,
   output logic [COL_W-1:0]             win_col,
   output logic                         frame_done
);

   // Input-raster counter widths.
   localparam int CNT_CW = $clog2(IMG_WIDTH);
   localparam int CNT_RW = $clog2(IMG_HEIGHT);

   localparam logic [CNT_CW-1:0] COL_LAST = CNT_CW'(IMG_WIDTH - 1);
   localparam logic [CNT_RW-1:0] ROW_LAST = CNT_RW'(IMG_HEIGHT - 1);

   // Position of the next pixel to be accepted.
   logic [CNT_CW-1:0] col_cnt;
   logic [CNT_RW-1:0] row_cnt;

   // One even row of pixels; entries are only read on the following odd row.
   logic signed [DATA_WIDTH-1:0] line_buf [0:IMG_WIDTH-1];

   // Bottom-left pixel of the window currently being assembled.
   logic signed [DATA_WIDTH-1:0] held_bl;

   // Decoded per-pixel actions.
   logic              take;       // pixel accepted this cycle (reset has priority)
   logic              col_last;
   logic              row_last;
   logic              buf_wr;     // even row: store into line buffer
   logic              bl_wr;      // odd row, even column: hold bottom-left
   logic              emit;       // odd row, odd column: window complete
   logic [CNT_CW-1:0] col_left;   // column of the top-left element (col_cnt with bit 0 cleared)

   // Decode what the current pixel does based on its raster position.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves
      // a signal unassigned and no latch is inferred.
      take     = 1'b0;
      col_last = 1'b0;
      row_last = 1'b0;
      buf_wr   = 1'b0;
      bl_wr    = 1'b0;
      emit     = 1'b0;
      col_left = col_cnt & ~CNT_CW'(1);

      take     = pix_valid && !rst;
      col_last = (col_cnt == COL_LAST);
      row_last = (row_cnt == ROW_LAST);

      if (take) begin
         if (!row_cnt[0]) begin
            buf_wr = 1'b1;
         end else if (!col_cnt[0]) begin
            bl_wr = 1'b1;
         end else begin
            // With an odd IMG_WIDTH the last column is even, so it never lands here.
            emit = 1'b1;
         end
      end
   end

   // Raster position counters: advance only on accepted pixels, wrap per row and frame.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (pix_valid) begin
         if (col_last) begin
            col_cnt <= '0;
            row_cnt <= row_last ? '0 : row_cnt + 1'b1;
         end else begin
            col_cnt <= col_cnt + 1'b1;
         end
      end
   end

   // Pixel storage: line buffer for even rows and the held bottom-left pixel.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; its contents are always written
      // before they are read, and leaving it out of reset lets it map to RAM.
      if (buf_wr) begin
         line_buf[col_cnt] <= pix_in;
      end
      if (bl_wr) begin
         held_bl <= pix_in;
      end
   end

   // Registered window outputs and end-of-frame pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < POOL_SIZE; i++) begin
            win_out[i] <= '0;
         end
         win_valid  <= 1'b0;
         win_row    <= '0;
         win_col    <= '0;
         frame_done <= 1'b0;
      end else begin
         win_valid  <= emit;
         frame_done <= take && col_last && row_last;
         // win_out and coordinates hold their last window between emissions.
         if (emit) begin
            win_out[0] <= line_buf[col_left];
            win_out[1] <= line_buf[col_cnt];
            win_out[2] <= held_bl;
            win_out[3] <= pix_in;
            win_row    <= ROW_W'(row_cnt >> 1);
            win_col    <= COL_W'(col_cnt >> 1);
         end
      end
   end

endmodule

// File: tb/tb_pool_window_gen.sv
// Testbench for pool_window_gen: drives a 4x4 and a 5x5 instance with directed
// frames and compares every emitted window against hand-written tables.
module tb_pool_window_gen;

   typedef struct {
      int idx[4];   // raster indices (within the frame) of TL, TR, BL, BR
      int row;
      int col;
      int after;    // raster index of the pixel whose acceptance emits the window
   } vec_t;

   typedef struct {
      logic signed [7:0] w[4];
      int                row;
      int                col;
      int                after;   // global index of the last accepted pixel
      bit                fresh;   // a pixel was accepted on the preceding edge
   } cap_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic signed [7:0] pix_in = '0;
   logic              pix_valid = 1'b0;
   logic              sel5 = 1'b0;

   logic              pv4, pv5;
   logic signed [7:0] w4 [3:0];
   logic signed [7:0] w5 [3:0];
   logic              v4, v5, fd4, fd5;
   logic [0:0]        r4, c4, r5, c5;

   assign pv4 = pix_valid && !sel5;
   assign pv5 = pix_valid && sel5;

   pool_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .POOL_SIZE(4)) dut4 (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pv4),
      .win_out(w4), .win_valid(v4), .win_row(r4), .win_col(c4), .frame_done(fd4)
   );

   pool_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(5), .POOL_SIZE(4)) dut5 (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pv5),
      .win_out(w5), .win_valid(v5), .win_row(r5), .win_col(c5), .frame_done(fd5)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic signed [7:0] stim [0:63];
   vec_t t4 [4];
   vec_t t5 [4];

   cap_t cap4[$];
   cap_t cap5[$];
   cap_t fdq4[$];
   cap_t fdq5[$];

   int pix_idx  = 0;
   int last_acc = -1;
   bit acc_now  = 1'b0;

   // Track which global pixel index was accepted on the latest edge.
   always @(posedge clk) begin
      acc_now <= pix_valid && !rst;
      if (pix_valid && !rst) begin
         last_acc <= pix_idx;
         pix_idx  <= pix_idx + 1;
      end
   end

   function automatic cap_t mk_cap(input logic signed [7:0] a, input logic signed [7:0] b,
                                   input logic signed [7:0] c, input logic signed [7:0] d,
                                   input int row, input int col);
      cap_t r;
      r.w[0]  = a;
      r.w[1]  = b;
      r.w[2]  = c;
      r.w[3]  = d;
      r.row   = row;
      r.col   = col;
      r.after = last_acc;
      r.fresh = acc_now;
      return r;
   endfunction

   // Capture every valid window and frame_done pulse, away from the rising edge.
   always @(negedge clk) begin
      if (v4)  cap4.push_back(mk_cap(w4[0], w4[1], w4[2], w4[3], int'(r4), int'(c4)));
      if (v5)  cap5.push_back(mk_cap(w5[0], w5[1], w5[2], w5[3], int'(r5), int'(c5)));
      if (fd4) fdq4.push_back(mk_cap(w4[0], w4[1], w4[2], w4[3], int'(r4), int'(c4)));
      if (fd5) fdq5.push_back(mk_cap(w5[0], w5[1], w5[2], w5[3], int'(r5), int'(c5)));
   end

   function automatic vec_t mk_vec(input int a, input int b, input int c, input int d,
                                   input int row, input int col, input int after);
      vec_t v;
      v.idx[0] = a;
      v.idx[1] = b;
      v.idx[2] = c;
      v.idx[3] = d;
      v.row    = row;
      v.col    = col;
      v.after  = after;
      return v;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send(input logic signed [7:0] v);
      @(negedge clk);
      pix_in    = v;
      pix_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pix_valid = 1'b0;
      end
   endtask

   // Feed n stimulus pixels, optionally with random idle gaps (~50%).
   task automatic feed(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && ($urandom_range(1) == 1)) idle(1 + $urandom_range(2));
         send(stim[i]);
      end
      idle(3);
   endtask

   // Compare captured windows/frame_done pulses (from queue offsets c0/f0)
   // against nfr back-to-back frames of the table for the chosen instance.
   task automatic check_caps(input bit is5, input int nfr, input int base,
                             input int c0, input int f0);
      int   np;
      int   got_n;
      int   got_f;
      int   nwin;
      vec_t e;
      cap_t g;
      np    = is5 ? 25 : 16;
      nwin  = nfr * 4;
      got_n = (is5 ? cap5.size() : cap4.size()) - c0;
      got_f = (is5 ? fdq5.size() : fdq4.size()) - f0;
      check("win_count", got_n, nwin);
      for (int k = 0; k < nwin && k < got_n; k++) begin
         int f;
         int i;
         f = k / 4;
         i = k % 4;
         if (is5) begin
            e = t5[i];
            g = cap5[c0 + k];
         end else begin
            e = t4[i];
            g = cap4[c0 + k];
         end
         for (int j = 0; j < 4; j++) check("win_elem", g.w[j], stim[f * np + e.idx[j]]);
         check("win_row", g.row, e.row);
         check("win_col", g.col, e.col);
         check("win_latency_px", g.after, base + f * np + e.after);
         check("win_latency_edge", g.fresh, 1);
      end
      check("frame_done_count", got_f, nfr);
      for (int f = 0; f < nfr && f < got_f; f++) begin
         if (is5) g = fdq5[f0 + f];
         else     g = fdq4[f0 + f];
         check("frame_done_px", g.after, base + f * np + np - 1);
         check("frame_done_edge", g.fresh, 1);
      end
   endtask

   task automatic check_zero4(input string tag);
      for (int j = 0; j < 4; j++) check({tag, "_win"}, w4[j], 0);
      check({tag, "_valid"}, v4, 0);
      check({tag, "_row"}, r4, 0);
      check({tag, "_col"}, c4, 0);
      check({tag, "_fdone"}, fd4, 0);
   endtask

   initial begin
      int base;
      int c0;
      int f0;
      logic signed [7:0] pat [4];

      // 4x4 windows: indices within a 16-pixel frame.
      t4[0] = mk_vec(0, 1, 4, 5, 0, 0, 5);
      t4[1] = mk_vec(2, 3, 6, 7, 0, 1, 7);
      t4[2] = mk_vec(8, 9, 12, 13, 1, 0, 13);
      t4[3] = mk_vec(10, 11, 14, 15, 1, 1, 15);
      // 5x5 windows: last column and last row never used.
      t5[0] = mk_vec(0, 1, 5, 6, 0, 0, 6);
      t5[1] = mk_vec(2, 3, 7, 8, 0, 1, 8);
      t5[2] = mk_vec(10, 11, 15, 16, 1, 0, 16);
      t5[3] = mk_vec(12, 13, 17, 18, 1, 1, 18);

      // Reset state of both instances.
      repeat (2) @(negedge clk);
      check_zero4("reset");
      check("reset5_valid", v5, 0);
      check("reset5_fdone", fd5, 0);
      check("reset5_win0", w5[0], 0);
      rst = 1'b0;
      idle(1);

      // 4x4 continuous, pixels 0..15.
      for (int i = 0; i < 16; i++) stim[i] = 8'(i);
      base = pix_idx; c0 = cap4.size(); f0 = fdq4.size();
      feed(16, 1'b0);
      check_caps(1'b0, 1, base, c0, f0);
      check("hold_valid", v4, 0);
      check("hold_w3", w4[3], 15);
      check("hold_w0", w4[0], 10);

      // Same frame with random gaps.
      base = pix_idx; c0 = cap4.size(); f0 = fdq4.size();
      feed(16, 1'b1);
      check_caps(1'b0, 1, base, c0, f0);

      // Signed extremes, patterned, with gaps.
      pat[0] = -8'sd128; pat[1] = 8'sd127; pat[2] = -8'sd1; pat[3] = 8'sd0;
      for (int i = 0; i < 16; i++) stim[i] = pat[(i + i / 4) % 4];
      base = pix_idx; c0 = cap4.size(); f0 = fdq4.size();
      feed(16, 1'b1);
      check_caps(1'b0, 1, base, c0, f0);

      // 5x5 frame, pixels 0..24: frame_done after pixel 24 with no window.
      sel5 = 1'b1;
      for (int i = 0; i < 25; i++) stim[i] = 8'(i);
      base = pix_idx; c0 = cap5.size(); f0 = fdq5.size();
      feed(25, 1'b0);
      check_caps(1'b1, 1, base, c0, f0);
      sel5 = 1'b0;

      // Reset mid-frame after 6 pixels; reset wins over a simultaneous pixel.
      for (int i = 0; i < 6; i++) send(8'(50 + i));
      @(negedge clk);
      rst = 1'b1; pix_valid = 1'b1; pix_in = 8'sd77;
      @(negedge clk);
      check_zero4("in_rst1");
      @(negedge clk);
      check_zero4("in_rst2");
      rst = 1'b0; pix_valid = 1'b0;
      @(negedge clk);
      check_zero4("post_rst");
      for (int i = 0; i < 16; i++) stim[i] = 8'(100 + i);
      base = pix_idx; c0 = cap4.size(); f0 = fdq4.size();
      feed(16, 1'b0);
      check_caps(1'b0, 1, base, c0, f0);

      // Two frames back-to-back, pixels 0..31.
      for (int i = 0; i < 32; i++) stim[i] = 8'(i);
      base = pix_idx; c0 = cap4.size(); f0 = fdq4.size();
      feed(32, 1'b0);
      check_caps(1'b0, 2, base, c0, f0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
